alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue controller that drives the ALU datapath from the requester side.
//  - Accepts 16-bit instructions over a valid/ready handshake.
//  - Reads operands from an internal register file and drives the ALU input ports
//    (R2, R3, m, OP, insta).
//  - Captures the ALU outputs (R1, flags) and writes the result back into the register file.
//  - Sits between the instruction source and the combinational ALU.
// PARAMETERS
//  DATA_W  16  datapath width; must match the ALU size
//  NREG    8   register file depth; fixed by the 3-bit register fields
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       synchronous, active-low reset
//  instr_valid  in   1       instruction/immediate word valid
//  instr_ready  out  1       controller can accept a word this cycle
//  instr        in   16      instruction word, or immediate word after LDI
//  alu_a        out  DATA_W  operand A -> ALU R2
//  alu_b        out  DATA_W  operand B -> ALU R3
//  alu_m        out  4       shift/rotate amount -> ALU m
//  alu_op       out  4       opcode -> ALU OP
//  alu_imm      out  DATA_W  immediate -> ALU insta
//  alu_result   in   DATA_W  ALU R1
//  alu_flags    in   4       ALU flags
//  flags_o      out  4       latched flags of last executed op
//  busy         out  1       high in any state except IDLE/IMM
//  done         out  1       one-cycle pulse at instruction retire
//  err          out  1       one-cycle pulse with done for reserved opcode
//  dbg_addr     in   3       debug read address
//  dbg_data     out  DATA_W  regfile[dbg_addr], combinational
// BEHAVIOUR
//  Instruction format: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:2] m (ops 6-8 only).
//  Opcodes: 0 ADD, 1 SUB, 2 MULT, 3 OR, 4 AND, 5 XOR, 6 SHR, 7 SHL, 8 ROR, 9 LDI, 10 CMP, 11-15 reserved.
//  Handshake: a word transfers on a rising edge with instr_valid && instr_ready.
//   - instr_ready = 1 only in IDLE and IMM.
//   - instr is don't-care when instr_valid = 0.
//  FSM states: IDLE, IMM, OPRD, EXEC, WB.
//   IDLE: on accept, latch instr.
//    - op 9 -> IMM.
//    - op 11-15 -> IDLE, with done=1 and err=1 the next cycle; no ALU drive, no regfile or flag change.
//    - all other ops -> OPRD.
//   IMM: on accept, latch the word as imm_q -> OPRD. Waits indefinitely.
//   OPRD: at the edge, load alu_a <= rf[rs1], alu_b <= rf[rs2], alu_m <= instr[5:2] (0 unless op 6-8),
//    alu_op <= op, alu_imm <= imm_q (0 unless op 9) -> EXEC.
//   EXEC: ALU ports are stable for the whole cycle. At the edge: res_q <= alu_result,
//    flags_o <= alu_flags -> WB.
//   WB: at the edge: rf[rd] <= res_q, except CMP (op 10), which writes nothing.
//    done <= 1 -> IDLE.
//  Latency: accept at edge T0 -> rf written and done high after edge T3 (4 cycles; LDI is 4 cycles
//   after the immediate word). Next instruction is accepted no earlier than edge T4.
//  alu_* outputs are registered and hold their values until the next OPRD. done and err are
//   registered one-cycle pulses.
//  All registers, including r0, are ordinary read/write. rd == rs1 == rs2 is legal; operands are
//   read before the writeback.
//  Reset (rst_n low at any edge, including mid-instruction or in IMM):
//   - state <= IDLE; the in-flight instruction is discarded without writeback.
//   - all 8 registers, alu_*, flags_o, res_q and imm_q <= 0; done = err = busy = 0; instr_ready = 1
//     from the first cycle after reset.
//  Arithmetic, shift and flag semantics are defined entirely by the ALU; results are truncated to DATA_W.
// TESTING (bench connects the real ALU to the alu_* ports)
//  1. Hold rst_n low 2 cycles -> all outputs 0, instr_ready=1, dbg_data=0 for dbg_addr 0..7.
//  2. Send 0x9200 then 0x1234 (LDI r1); send 0x9400 then 0x0005 (LDI r2)
//     -> dbg r1=0x1234, r2=0x0005; done 4 cycles after each immediate word.
//  3. Send 0x0650 (ADD r3,r1,r2) -> during EXEC alu_a=0x1234, alu_b=0x0005, alu_op=0;
//     r3=0x1239 with done exactly 4 cycles after accept.
//     Hold instr_valid high through busy -> no second accept until IDLE.
//  4. Send 0x7850 (SHL r4,r1,m=4) -> alu_m=4, alu_op=7, r4=0x2340.
//     Send 0xA050 (CMP r1,r2) -> flags_o updated, no register changed.
//  5. Send 0xF000 -> done and err both high for exactly 1 cycle the next cycle;
//     registers and flags_o unchanged.
//  6. Send 0x9200, pulse rst_n low 1 cycle, then send 0x0650 -> treated as ADD (not as an
//     immediate); r3=0x0000; no write to r1.

Source files
------------

// File: rtl/alu_issue_if.sv
// Instruction handshake plus ALU operand/result bus between the issue controller and its environment.
interface alu_issue_if #(
    parameter int DATA_W = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_m;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_imm;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

    // Requester plus combinational ALU side.
    modport master (
        output instr_valid, instr, alu_result, alu_flags,
        input  instr_ready, alu_a, alu_b, alu_m, alu_op, alu_imm
    );

    // Issue controller side.
    modport slave (
        input  instr_valid, instr, alu_result, alu_flags,
        output instr_ready, alu_a, alu_b, alu_m, alu_op, alu_imm
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts instructions, reads operands from an 8-entry register file,
// drives a combinational ALU, and writes the captured result back.
//
// state | meaning
// IDLE  | waiting for an instruction word
// IMM   | LDI accepted, waiting for the immediate word
// OPRD  | reading operands, loading ALU ports
// EXEC  | ALU ports stable, capturing result and flags
// WB    | writing result back, retiring
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_if.slave        bus,
    output logic [3:0]        flags_o,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic [2:0] {S_IDLE, S_IMM, S_OPRD, S_EXEC, S_WB} state_t;

    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_LDI = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;

    state_t            state_q;
    logic [13:0]       instr_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [DATA_W-1:0] alu_imm_q;
    logic [3:0]        alu_m_q;
    logic [3:0]        alu_op_q;
    logic [3:0]        flags_q;
    logic              done_q;
    logic              err_q;

    logic              ready;
    logic              accept;
    logic [3:0]        in_op;
    logic [3:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic [3:0]        alu_m_d;
    logic [DATA_W-1:0] alu_imm_d;

    // instr_q keeps bits [15:2]; bits [1:0] carry no field.
    assign op     = instr_q[13:10];
    assign rd     = instr_q[9:7];
    assign rs1    = instr_q[6:4];
    assign rs2    = instr_q[3:1];
    assign in_op  = bus.instr[15:12];

    assign ready  = (state_q == S_IDLE) || (state_q == S_IMM);
    assign accept = bus.instr_valid && ready;

    assign alu_m_d   = (op >= OP_SHR && op <= OP_ROR) ? instr_q[3:0] : 4'd0;
    assign alu_imm_d = (op == OP_LDI) ? imm_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_imm_q <= '0;
            alu_m_q   <= '0;
            alu_op_q  <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        instr_q <= bus.instr[15:2];
                        if (in_op == OP_LDI) begin
                            state_q <= S_IMM;
                        end else if (in_op > OP_CMP) begin
                            // Reserved opcode retires at once with an error and touches nothing.
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state_q <= S_OPRD;
                        end
                    end
                end
                S_IMM: begin
                    if (accept) begin
                        imm_q   <= DATA_W'(bus.instr);
                        state_q <= S_OPRD;
                    end
                end
                S_OPRD: begin
                    alu_a_q   <= rf_q[rs1];
                    alu_b_q   <= rf_q[rs2];
                    alu_m_q   <= alu_m_d;
                    alu_op_q  <= op;
                    alu_imm_q <= alu_imm_d;
                    state_q   <= S_EXEC;
                end
                S_EXEC: begin
                    res_q   <= bus.alu_result;
                    flags_q <= bus.alu_flags;
                    state_q <= S_WB;
                end
                S_WB: begin
                    if (op != OP_CMP) begin
                        rf_q[rd] <= res_q;
                    end
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = ready;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_m       = alu_m_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_imm     = alu_imm_q;

    assign flags_o  = flags_q;
    assign busy     = !ready;
    assign done     = done_q;
    assign err      = err_q;
    assign dbg_data = rf_q[dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a stand-in combinational ALU, a transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  flags_o;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  dbg_addr = 3'd0;
    logic [15:0] dbg_data;

    alu_issue_if bus ();

    alu_issue_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flags_o  (flags_o),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #10 clk = ~clk;

    // Stand-in ALU: flags = {a<b, parity(r), r[15], r==0}.
    function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] m,
                                          input logic [15:0] im);
        logic [15:0] r;
        logic [31:0] prod;
        logic [31:0] rot;
        prod = 32'(a) * 32'(b);
        rot  = {a, a} >> m;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = prod[15:0];
            4'd3:    r = a | b;
            4'd4:    r = a & b;
            4'd5:    r = a ^ b;
            4'd6:    r = a >> m;
            4'd7:    r = a << m;
            4'd8:    r = rot[15:0];
            4'd9:    r = im;
            4'd10:   r = a - b;
            default: r = 16'h0;
        endcase
        return {a < b, ^r, r[15], r == 16'h0, r};
    endfunction

    always_comb {bus.alu_flags, bus.alu_result} = alu_f(bus.alu_op, bus.alu_a, bus.alu_b,
                                                       bus.alu_m, bus.alu_imm);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: architectural registers, visible ALU ports, one pending instruction.
    logic [15:0] m_rf [8];
    logic [15:0] dut_rf [8];
    logic [15:0] m_a, m_b, m_imm;
    logic [3:0]  m_m, m_op, m_flags;
    bit          started = 1'b0;
    bit          wait_imm;
    logic [15:0] ldi_word;
    bit          p_act, p_wr, r_act;
    int          p_edge, r_cyc;
    logic [15:0] p_a, p_b, p_imm, p_res;
    logic [3:0]  p_m, p_op, p_flags;
    logic [2:0]  p_rd;
    int          acc_cnt = 0;
    int          last_acc_edge = 0;
    int          last_dut_done = -1;
    int          err_cycles = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_a = 0; m_b = 0; m_imm = 0; m_m = 0; m_op = 0; m_flags = 0;
        wait_imm = 0; p_act = 0; r_act = 0;
    endtask

    task automatic make_pending(input logic [15:0] w, input logic [15:0] imm, input int edge_no);
        logic [19:0] fr;
        p_op  = w[15:12];
        p_a   = m_rf[w[8:6]];
        p_b   = m_rf[w[5:3]];
        p_m   = (p_op >= 4'd6 && p_op <= 4'd8) ? w[5:2] : 4'd0;
        p_imm = (p_op == 4'd9) ? imm : 16'h0;
        fr    = alu_f(p_op, p_a, p_b, p_m, p_imm);
        p_flags = fr[19:16];
        p_res = fr[15:0];
        p_rd  = w[11:9];
        p_wr  = (p_op != 4'd10);
        p_edge = edge_no;
        p_act = 1;
    endtask

    always @(negedge clk) begin
        bit exp_done, exp_err;
        exp_done = 0;
        exp_err  = 0;
        if (r_act && cyc == r_cyc) begin
            exp_done = 1; exp_err = 1; r_act = 0;
        end
        if (p_act && cyc == p_edge + 1) begin
            m_a = p_a; m_b = p_b; m_m = p_m; m_op = p_op; m_imm = p_imm;
        end
        if (p_act && cyc == p_edge + 2) m_flags = p_flags;
        if (p_act && cyc == p_edge + 3) begin
            exp_done = 1;
            if (p_wr) m_rf[p_rd] = p_res;
            p_act = 0;
        end
        if (started) begin
            if (done === 1'b1) last_dut_done = cyc;
            if (err === 1'b1) err_cycles++;
            chk("done", 32'(done), 32'(exp_done));
            chk("err", 32'(err), 32'(exp_err));
            chk("busy", 32'(busy), 32'(p_act));
            chk("instr_ready", 32'(bus.instr_ready), 32'(!p_act));
            chk("flags_o", 32'(flags_o), 32'(m_flags));
            chk("alu_a", 32'(bus.alu_a), 32'(m_a));
            chk("alu_b", 32'(bus.alu_b), 32'(m_b));
            chk("alu_m", 32'(bus.alu_m), 32'(m_m));
            chk("alu_op", 32'(bus.alu_op), 32'(m_op));
            chk("alu_imm", 32'(bus.alu_imm), 32'(m_imm));
            for (int i = 0; i < 8; i++) begin
                dbg_addr = 3'(i);
                #1;
                dut_rf[i] = dbg_data;
                chk($sformatf("dbg_r%0d", i), 32'(dbg_data), 32'(m_rf[i]));
            end
        end
        // Decide what the coming rising edge does.
        if (rst_n !== 1'b1) begin
            model_reset();
            started = 1;
        end else if (started && bus.instr_valid && !p_act) begin
            acc_cnt++;
            last_acc_edge = cyc + 1;
            if (wait_imm) begin
                make_pending(ldi_word, bus.instr, cyc + 1);
                wait_imm = 0;
            end else if (bus.instr[15:12] == 4'd9) begin
                wait_imm = 1;
                ldi_word = bus.instr;
            end else if (bus.instr[15:12] > 4'd10) begin
                r_act = 1;
                r_cyc = cyc + 1;
            end else begin
                make_pending(bus.instr, 16'h0, cyc + 1);
            end
        end
    end

    task automatic send(input logic [15:0] w);
        int n0;
        bit ok;
        n0 = acc_cnt;
        ok = 0;
        bus.instr_valid = 1'b1;
        bus.instr = w;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != n0) begin
                ok = 1;
                break;
            end
        end
        chk("accept_within_bound", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        bus.instr_valid = 1'b0;
        bus.instr = 16'($urandom);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, e0;
        logic [15:0] w;
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'(flags_o), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_r%0d", i), 32'(dut_rf[i]), 32'd0);

        send(16'h9200); send(16'h1234);
        idle(5);
        chk("ldi_done_latency", 32'(last_dut_done - last_acc_edge), 32'd3);
        send(16'h9400); send(16'h0005);
        idle(5);
        chk("ldi_r1", 32'(dut_rf[1]), 32'h1234);
        chk("ldi_r2", 32'(dut_rf[2]), 32'h0005);

        send(16'h0650);
        idle(5);
        chk("add_done_latency", 32'(last_dut_done - last_acc_edge), 32'd3);
        chk("add_r3", 32'(dut_rf[3]), 32'h1239);

        send(16'h7850); a1 = last_acc_edge;
        send(16'hA050); a2 = last_acc_edge;
        chk("held_valid_accept_gap", 32'(a2 - a1), 32'd4);
        idle(5);
        chk("shl_r4", 32'(dut_rf[4]), 32'h2340);
        chk("cmp_flags", 32'(flags_o), 32'h4);
        chk("cmp_r0_untouched", 32'(dut_rf[0]), 32'h0);
        chk("cmp_r1_untouched", 32'(dut_rf[1]), 32'h1234);

        e0 = err_cycles;
        send(16'hF000);
        idle(4);
        chk("rsv_err_cycles", 32'(err_cycles - e0), 32'd1);
        chk("rsv_done_next_cycle", 32'(last_dut_done - last_acc_edge), 32'd0);
        chk("rsv_flags_kept", 32'(flags_o), 32'h4);
        chk("rsv_r0_kept", 32'(dut_rf[0]), 32'h0);

        send(16'h9200);
        pulse_reset();
        send(16'h0650);
        idle(5);
        chk("rst_in_imm_r3", 32'(dut_rf[3]), 32'h0);
        chk("rst_in_imm_r1", 32'(dut_rf[1]), 32'h0);

        send(16'h9200); send(16'hBEEF);
        send(16'h9400); send(16'h0003);
        for (int n = 0; n < 250; n++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(w);
            if (w[15:12] == 4'd9) begin
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
                send(16'($urandom));
            end
            if ($urandom_range(0, 24) == 0) begin
                idle($urandom_range(0, 3));
                pulse_reset();
            end
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
